// File: rtl/sync_pulse_rx.sv
// Destination end of a four-phase req/ack pulse crossing: synchronizes req_in,
// delivers one registered pulse plus captured data per request, returns a level ack.
module sync_pulse_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  input  logic              cnt_clr,
  output logic              ack_out,
  output logic              pulse_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [CNT_W-1:0]  pulse_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [1:0]             state_q, state_d;
  logic                   deliver;
  logic                   pulse_q;
  logic                   ack_q;
  logic                   busy_q;
  logic [DATA_W-1:0]      data_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // req_in feeds only the first synchronizer flop; everything else sees req_s.
  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    deliver = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          if (ready_in) begin
            deliver = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (ready_in) begin
          deliver = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear coincident with a delivery leaves that delivery counted.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = deliver ? CNT_W'(1) : '0;
    end else if (deliver && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_in};
      state_q <= state_d;
      pulse_q <= deliver;
      ack_q   <= (state_d == ST_ACK);
      busy_q  <= (state_d != ST_IDLE);
      cnt_q   <= cnt_d;
      if (deliver) data_q <= data_in;
    end
  end

  assign ack_out   = ack_q;
  assign pulse_out = pulse_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_sync_pulse_rx.sv
// Directed bench for sync_pulse_rx: default instance (SYNC_STAGES=2) plus a SYNC_STAGES=3 instance.
module tb_sync_pulse_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_in, req3;
  logic [7:0] data_in;
  logic       ready_in;
  logic       cnt_clr;
  logic       ack_out, pulse_out, busy;
  logic [7:0] data_out, pulse_cnt;
  logic       ack3, pulse3, busy3;
  logic [7:0] data3, cnt3;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulses3 = 0;

  sync_pulse_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ready_in(ready_in),
    .cnt_clr(cnt_clr), .ack_out(ack_out), .pulse_out(pulse_out), .data_out(data_out),
    .busy(busy), .pulse_cnt(pulse_cnt)
  );

  sync_pulse_rx #(.DATA_W(8), .SYNC_STAGES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .req_in(req3), .data_in(data_in), .ready_in(ready_in),
    .cnt_clr(cnt_clr), .ack_out(ack3), .pulse_out(pulse3), .data_out(data3),
    .busy(busy3), .pulse_cnt(cnt3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pulse_out) pulses++;
    if (pulse3) pulses3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 1'b0; req3 = 1'b0; data_in = 8'h00; ready_in = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({ack_out, pulse_out, busy, data_out, pulse_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got ack=%b pulse=%b busy=%b data=%h cnt=%0d exp all zero",
               ack_out, pulse_out, busy, data_out, pulse_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_in = 1'b1; data_in = 8'hA5;
    tick(); tick();
    checks++;
    if (pulse_out !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", pulse_out); end
    tick();
    checks++;
    if ({pulse_out, ack_out, busy} !== 3'b111) begin
      errors++; $display("FAIL single_pulse got pulse/ack/busy=%b exp=111", {pulse_out, ack_out, busy});
    end
    checks++;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", data_out); end
    checks++;
    if (pulse_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", pulse_cnt); end
    tick();
    checks++;
    if ({pulse_out, ack_out} !== 2'b01) begin
      errors++; $display("FAIL single_one_cycle got pulse/ack=%b exp=01", {pulse_out, ack_out});
    end
    req_in = 1'b0;
    tick(); tick();
    checks++;
    if (ack_out !== 1'b1) begin errors++; $display("FAIL release_early got=%b exp=1", ack_out); end
    tick();
    checks++;
    if ({ack_out, busy} !== 2'b00) begin
      errors++; $display("FAIL release got ack/busy=%b exp=00", {ack_out, busy});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = pulses;
    ready_in = 1'b0; req_in = 1'b1; data_in = 8'h3C;
    repeat (6) tick();
    checks++;
    if ({busy, ack_out, pulses - p0} !== {2'b10, 32'd0}) begin
      errors++; $display("FAIL bp_hold got busy=%b ack=%b pulses=%0d exp busy=1 ack=0 pulses=0",
                         busy, ack_out, pulses - p0);
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if ({pulse_out, ack_out, data_out} !== {2'b11, 8'h3C}) begin
      errors++; $display("FAIL bp_deliver got pulse=%b ack=%b data=%h exp 1 1 3c", pulse_out, ack_out, data_out);
    end
    ready_in = 1'b0;
    tick(); tick();
    checks++;
    if ({pulse_out, ack_out} !== 2'b01) begin
      errors++; $display("FAIL bp_ready_ignored_in_ack got pulse/ack=%b exp=01", {pulse_out, ack_out});
    end
    req_in = 1'b0;
    repeat (4) tick();
    ready_in = 1'b1;
  endtask

  task automatic test_abort();
    int p0;
    logic [7:0] c0;
    p0 = pulses; c0 = pulse_cnt;
    ready_in = 1'b0; req_in = 1'b1; data_in = 8'h77;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_hold got busy=%b exp=1", busy); end
    req_in = 1'b0;
    repeat (4) tick();
    ready_in = 1'b1;
    tick();
    checks++;
    if ({busy, ack_out} !== 2'b00 || pulses != p0 || pulse_cnt !== c0) begin
      errors++; $display("FAIL abort got busy=%b ack=%b pulses=%0d cnt=%0d exp 0 0 0 %0d",
                         busy, ack_out, pulses - p0, pulse_cnt, c0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [7:0] w;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      w = 8'($urandom);
      data_in = w; req_in = 1'b1;
      for (int k = 0; k < 20 && !ack_out; k++) tick();
      checks++;
      if (ack_out !== 1'b1 || data_out !== w) begin
        errors++; $display("FAIL b2b_word[%0d] got ack=%b data=%h exp ack=1 data=%h", i, ack_out, data_out, w);
      end
      req_in = 1'b0;
      for (int k = 0; k < 20 && ack_out; k++) tick();
      if (ack_out !== 1'b0) begin
        checks++; errors++; $display("FAIL b2b_release[%0d] got ack=%b exp=0", i, ack_out);
      end
    end
    tick();
    checks++;
    if (pulses - p0 != 300) begin errors++; $display("FAIL b2b_pulses got=%0d exp=300", pulses - p0); end
    checks++;
    if (pulse_cnt !== 8'd255) begin errors++; $display("FAIL cnt_saturate got=%0d exp=255", pulse_cnt); end
    // cnt_clr during the delivery edge
    req_in = 1'b1; data_in = 8'h5A;
    tick(); tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if ({pulse_out, pulse_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL cnt_clr_with_pulse got pulse=%b cnt=%0d exp 1 1", pulse_out, pulse_cnt);
    end
    req_in = 1'b0;
    repeat (4) tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++;
    if (pulse_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clr_alone got=%0d exp=0", pulse_cnt); end
  endtask

  task automatic test_reset_in_ack();
    int p0;
    req_in = 1'b1; data_in = 8'hC3;
    repeat (4) tick();
    checks++;
    if (ack_out !== 1'b1) begin errors++; $display("FAIL rst_ack_pre got ack=%b exp=1", ack_out); end
    rst = 1'b1;
    tick();
    checks++;
    if ({ack_out, pulse_out, busy, data_out, pulse_cnt} !== 19'd0) begin
      errors++; $display("FAIL rst_in_ack got ack=%b pulse=%b busy=%b data=%h cnt=%0d exp all zero",
                         ack_out, pulse_out, busy, data_out, pulse_cnt);
    end
    rst = 1'b0;
    p0 = pulses;
    tick(); tick();
    checks++;
    if (pulse_out !== 1'b0) begin errors++; $display("FAIL rst_repulse_early got=%b exp=0", pulse_out); end
    tick();
    checks++;
    if ({pulse_out, data_out} !== {1'b1, 8'hC3}) begin
      errors++; $display("FAIL rst_repulse got pulse=%b data=%h exp 1 c3", pulse_out, data_out);
    end
    repeat (4) tick();
    checks++;
    if (pulses - p0 != 1) begin errors++; $display("FAIL rst_one_pulse got=%0d exp=1", pulses - p0); end
    req_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_sync3();
    int p0;
    p0 = pulses3;
    for (int g = 0; g < 5; g++) begin
      #1 req3 = 1'b1;
      #3 req3 = 1'b0;
      tick();
    end
    repeat (4) tick();
    checks++;
    if (pulses3 != p0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL s3_glitch got pulses=%0d busy=%b exp 0 0", pulses3 - p0, busy3);
    end
    req3 = 1'b1; data_in = 8'h96;
    tick(); tick(); tick();
    checks++;
    if (pulse3 !== 1'b0) begin errors++; $display("FAIL s3_early got=%b exp=0", pulse3); end
    tick();
    checks++;
    if ({pulse3, ack3, data3} !== {2'b11, 8'h96}) begin
      errors++; $display("FAIL s3_pulse got pulse=%b ack=%b data=%h exp 1 1 96", pulse3, ack3, data3);
    end
    req3 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ack3 !== 1'b1) begin errors++; $display("FAIL s3_release_early got=%b exp=1", ack3); end
    tick();
    checks++;
    if (ack3 !== 1'b0) begin errors++; $display("FAIL s3_release got=%b exp=0", ack3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_reset_in_ack();
    test_sync3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_pulse_rx.md
# sync_pulse_rx

Destination end of the four-phase req/ack pulse-crossing handshake. Sits in the receiving clock domain. It synchronizes an asynchronous request level, emits exactly one single-cycle `pulse_out` per request, and captures the accompanying data word. It returns a level acknowledge to the source domain and supports downstream backpressure through `ready_in`.

## Interface
- `DATA_W`, 8: width of transferred data word.
- `SYNC_STAGES`, 2: flops in the `req_in` synchronizer chain; legal values ≥ 2.
- `CNT_W`, 8: width of the saturating delivered-pulse counter.

Ports:
- `clk`  in  1  sole clock, destination domain; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_in`  in  1  request level from source domain, asynchronous to `clk`.
- `data_in`  in  DATA_W  source data; held stable by source from before `req_in` rises until `ack_out` is seen high.
- `ready_in`  in  1  downstream can accept a pulse this cycle.
- `cnt_clr`  in  1  synchronous clear of `pulse_cnt`.
- `ack_out`  out  1  acknowledge level to source domain; registered.
- `pulse_out`  out  1  single-cycle delivery strobe; registered.
- `data_out`  out  DATA_W  captured word; valid with and after `pulse_out`.
- `busy`  out  1  FSM not in IDLE; registered.
- `pulse_cnt`  out  CNT_W  count of delivered pulses, saturating.

## Operation
- `req_in` passes through SYNC_STAGES flops → `req_s`. No other logic touches `req_in`.
- `data_in` is sampled only on the delivery edge. Source hold rules make it stable there; no separate data synchronizer.
- FSM states: IDLE, HOLD, ACK.
  - IDLE: `ack_out`=0. If `req_s`=1 and `ready_in`=1, capture `data_in` → `data_out`, assert `pulse_out` for one cycle, and go to ACK. If `req_s`=1 and `ready_in`=0, go to HOLD. Otherwise stay.
  - HOLD: If `req_s`=0, go to IDLE with no pulse and no ack (source abort; no delivery, no count). Else if `ready_in`=1, capture, pulse, and go to ACK.
  - ACK: `ack_out`=1. Stay until `req_s`=0, then go to IDLE and drive `ack_out` 0.
- One pulse per request. A new request is accepted only after `req_s` has been seen low in ACK, so no double pulses.
- `busy`=1 in HOLD and ACK.
- `pulse_cnt`:
  - +1 on every `pulse_out`.
  - Saturates at 2^CNT_W−1.
  - `cnt_clr` alone → 0.
  - `cnt_clr` and `pulse_out` in the same cycle → 1.
- `data_out` holds its last captured value until the next delivery.

## Timing
- Reset values: `ack_out`=0, `pulse_out`=0, `data_out`=0, `busy`=0, `pulse_cnt`=0, synchronizer chain=0, state=IDLE.
- Reset is synchronous: it takes effect at the first rising edge with `rst`=1.
- Latency with `ready_in`=1: `req_in` first sampled high at edge N → `pulse_out`, `ack_out`, `busy` and new `data_out` are all registered at edge N+SYNC_STAGES. `pulse_out` is high for exactly that one cycle.
- With backpressure: delivery occurs at the first edge where the FSM is in HOLD with `ready_in`=1. `ack_out` rises on the same edge.
- Release: `req_in` first sampled low at edge M (state ACK) → `ack_out` and `busy` fall at edge M+SYNC_STAGES.
- Minimum request cycle is 2·(SYNC_STAGES+1) destination edges plus source-side synchronization.
- Reset mid-operation:
  - All outputs return to reset values at the reset edge.
  - If `req_in` is still high after reset, it is treated as a new request and produces one pulse after SYNC_STAGES+1 edges.
- `ready_in` is examined only in IDLE (with `req_s`=1) and HOLD. Its value in ACK is ignored.

## Test plan
- Single transfer (SYNC_STAGES=2, `ready_in`=1). Raise `req_in` with `data_in`=0xA5 sampled at edge 10.
  - `pulse_out` high only after edge 12; `data_out`=0xA5, `ack_out`=1, `pulse_cnt`=1.
  - Drop `req_in` at edge 20 → `ack_out`=0 after edge 22.
- Backpressure: `ready_in`=0 while a request arrives → `busy`=1, no pulse, `ack_out`=0. Raise `ready_in` at edge 30 → one pulse and `ack_out`=1 after edge 30.
- Abort: a request arrives with `ready_in`=0, then `req_in` drops → FSM returns to IDLE. `pulse_out` never asserts, `pulse_cnt` unchanged, `ack_out` stays 0.
- Back-to-back:
  - Run 300 full handshakes with random `data_in` against a source model. Exactly 300 pulses, `data_out` matches each word.
  - `pulse_cnt` (CNT_W=8) saturates at 255.
  - `cnt_clr` alone → 0; `cnt_clr` coincident with a pulse → 1.
- Reset in ACK with `req_in` held high → outputs cleared at the reset edge. Exactly one new pulse SYNC_STAGES+1 edges after `rst` deasserts.
- Sweep SYNC_STAGES=3: pulse registered at edge N+3; `req_in` glitches shorter than one `clk` period with the source held low never produce a pulse in IDLE unless they are captured by the synchronizer.
